// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
// Keeps the slot width and FSM encoding consistent between the top and the slot counter.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/slot position tracker for the TDM demux: counts accepted bits within a slot
// and slots within a frame, and flags the last bit of a slot and of a frame.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    input  logic                 restart,
    input  logic                 clear,
    output logic [$clog2(W)-1:0] bitcnt,
    output slot_t                slot,
    output logic                 slot_last,
    output logic                 frame_last,
    output logic                 frame_start
);

    localparam int unsigned CW = $clog2(W);

    logic [CW-1:0] bitcnt_q, bitcnt_d;
    slot_t         slot_q, slot_d;

    assign slot_last   = (bitcnt_q == CW'(W - 1));
    assign frame_last  = slot_last && (slot_q == slot_t'(NUM_SLOTS - 1));
    assign frame_start = (bitcnt_q == '0) && (slot_q == '0);

    // clear beats restart beats adv; restart means "this bit was slot 0's MSB".
    always_comb begin
        bitcnt_d = bitcnt_q;
        slot_d   = slot_q;
        if (clear) begin
            bitcnt_d = '0;
            slot_d   = '0;
        end else if (restart) begin
            bitcnt_d = CW'(1);
            slot_d   = '0;
        end else if (adv) begin
            if (slot_last) begin
                bitcnt_d = '0;
                slot_d   = slot_q + slot_t'(1);
            end else begin
                bitcnt_d = bitcnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt_q <= '0;
            slot_q   <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            slot_q   <= slot_d;
        end
    end

    assign bitcnt = bitcnt_q;
    assign slot   = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer: recovers four W-bit channel words from a
// framed MSB-first serial stream, with valid strobes and frame-sync supervision.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         din_en,
    input  logic         fsync,
    output logic [W-1:0] ch0,
    output logic [W-1:0] ch1,
    output logic [W-1:0] ch2,
    output logic [W-1:0] ch3,
    output logic [3:0]   ch_valid,
    output logic         frame_done,
    output logic         sync_err,
    output logic         locked,
    output logic [1:0]   slot
);

    state_t         state_q, state_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W-1:0]   ch_q [NUM_SLOTS];
    logic [W-1:0]   ch_d [NUM_SLOTS];
    logic [3:0]     ch_valid_q, ch_valid_d;
    logic           frame_done_q, frame_done_d;
    logic           sync_err_q, sync_err_d;

    logic                 cnt_adv, cnt_restart, cnt_clear;
    logic [$clog2(W)-1:0] bitcnt;
    slot_t                cur_slot;
    logic                 slot_last, frame_last, frame_start;
    logic [W-1:0]         shift_in;

    tdm_slot_counter #(
        .W (W)
    ) u_slot_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .adv         (cnt_adv),
        .restart     (cnt_restart),
        .clear       (cnt_clear),
        .bitcnt      (bitcnt),
        .slot        (cur_slot),
        .slot_last   (slot_last),
        .frame_last  (frame_last),
        .frame_start (frame_start)
    );

    assign shift_in = {sh_q[W-2:0], din};

    always_comb begin
        state_d      = state_q;
        sh_d         = sh_q;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            ch_d[k] = ch_q[k];
        end
        ch_valid_d   = '0;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        cnt_adv      = 1'b0;
        cnt_restart  = 1'b0;
        cnt_clear    = 1'b0;

        if (din_en) begin
            unique case (state_q)
                HUNT: begin
                    if (fsync) begin
                        sh_d        = shift_in;
                        cnt_restart = 1'b1;
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (frame_start) begin
                        if (fsync) begin
                            sh_d    = shift_in;
                            cnt_adv = 1'b1;
                        end else begin
                            // Lost framing: drop this bit and re-acquire.
                            sync_err_d = 1'b1;
                            cnt_clear  = 1'b1;
                            state_d    = HUNT;
                        end
                    end else if (fsync) begin
                        // Misplaced fsync: abandon the partial slot, restart the frame here.
                        sync_err_d  = 1'b1;
                        sh_d        = {{(W-1){1'b0}}, din};
                        cnt_restart = 1'b1;
                    end else begin
                        sh_d    = shift_in;
                        cnt_adv = 1'b1;
                        if (slot_last) begin
                            ch_d[cur_slot]       = shift_in;
                            ch_valid_d[cur_slot] = 1'b1;
                            frame_done_d         = frame_last;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            sh_q         <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                ch_q[k] <= '0;
            end
            ch_valid_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                ch_q[k] <= ch_d[k];
            end
            ch_valid_q   <= ch_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign ch0        = ch_q[0];
    assign ch1        = ch_q[1];
    assign ch2        = ch_q[2];
    assign ch3        = ch_q[3];
    assign ch_valid   = ch_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == RUN);
    assign slot       = cur_slot;

    // At most one channel completes per edge, and a frame ends only with slot 3.
    assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ch_valid));
    assert property (@(posedge clk) disable iff (!rst_n) frame_done |-> ch_valid[3]);

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Receive-side counterpart of the team's 4:1 channel mux: a 1-to-4 time-division demultiplexer.
- Accepts a framed serial bit stream, MSB first: 4 slots of W bits each, with the frame start marked by fsync.
- Recovers the four channel words into registered outputs, with per-channel valid strobes and frame-sync supervision.
- Sits between a serial link front-end and parallel channel consumers.

Parameters:
- W, 8, bits per slot (channel word width); legal range 2..32.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- din  in  1  serial data bit.
- din_en  in  1  bit-enable; din and fsync are sampled only on edges where din_en=1.
- fsync  in  1  high with the first bit (slot 0, MSB) of each frame.
- ch0  out  W  last complete slot-0 word.
- ch1  out  W  last complete slot-1 word.
- ch2  out  W  last complete slot-2 word.
- ch3  out  W  last complete slot-3 word.
- ch_valid  out  4  one-cycle pulse; bit k set when chk has just been updated.
- frame_done  out  1  one-cycle pulse when slot 3 completes.
- sync_err  out  1  one-cycle pulse on a framing violation.
- locked  out  1  high while in RUN state.
- slot  out  2  slot index of the next bit expected (0 while in HUNT).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all ch* = 0, ch_valid = 0, frame_done = 0, sync_err = 0, locked = 0, slot = 0, state = HUNT, bit counter = 0, shift register = 0.
- Reset asserted mid-frame: partial data is discarded and no strobes are issued; after release the block re-hunts.
- Accepted bit: an edge where din_en=1. Edges with din_en=0 change nothing except clearing the pulse outputs.
- Pulse outputs (ch_valid, frame_done, sync_err) are registered and high for exactly one cycle.
- State HUNT:
  - Accepted bit with fsync=0: ignored.
  - Accepted bit with fsync=1: the bit is taken as slot 0 bit W-1 (MSB); bitcnt=1, slot=0; go to RUN.
- State RUN:
  - Each accepted bit shifts in: sh <= {sh[W-2:0], din}; bitcnt increments.
  - On the W-th bit of slot k: chk <= {sh[W-2:0], din} and ch_valid[k] <= 1 on that same edge; bitcnt -> 0; slot -> k+1 mod 4.
  - Latency: the word is visible the cycle after the edge that samples its LSB.
  - On completion of slot 3: frame_done <= 1 on the same edge as ch_valid[3]; slot wraps to 0.
- Sync checking in RUN:
  - Good frame start: the next accepted bit at slot=0, bitcnt=0 has fsync=1 (normal).
  - Missing fsync at frame start: sync_err pulse; go to HUNT; locked -> 0; that bit is discarded.
  - fsync=1 at any other position: sync_err pulse; the partial slot is discarded with no ch_valid; the bit is taken as the new frame start (slot=0, bitcnt=1); stay in RUN.
  - Slot-3 completion and a misplaced fsync cannot coincide on one edge.
- Channel outputs hold their values until overwritten; sync errors do not clear them.
- Gaps: din_en gaps of any length are tolerated inside a frame; there is no timeout.

Decomposition:
- Shared package tdm_pkg:
  - state enum {HUNT, RUN}.
  - Constant NUM_SLOTS=4.
  - Slot index typedef (2 bits).
- Natural sub-module: tdm_slot_counter. It holds bitcnt/slot, advances on din_en, and outputs slot_last and frame_last.
- Shift register, channel registers and FSM stay in the top module.

Test Plan:
- Basic frame (W=8): send frame 0xA5,0x3C,0xFF,0x01 MSB first, fsync on the first bit, din_en=1 continuously.
  - Expect ch_valid = 0001, 0010, 0100, 1000 at bit edges 8, 16, 24, 32.
  - Expect ch0..3 = A5, 3C, FF, 01, with frame_done on edge 32 and locked=1 from edge 1.
- Gapped enable: same frame with din_en toggling 1,0,0,1...
  - Expect identical words; valid only after the 8th accepted bit of each slot.
- HUNT filtering: 5 random bits with fsync=0, then a valid frame 0x11,0x22,0x33,0x44.
  - Expect locked=0 and no strobes during the junk bits.
  - Then ch0..3 = 11, 22, 33, 44.
- Missing fsync: after a good frame, send the next frame without fsync.
  - Expect sync_err pulse on the first bit, locked=0, ch0..3 unchanged (11, 22, 33, 44), no ch_valid until the next fsync.
- Early fsync: fsync at slot 1 bit 3, then a full frame 0x80,0x40,0x20,0x10.
  - Expect a sync_err pulse and no ch_valid[1] for the partial slot.
  - Then ch0..3 = 80, 40, 20, 10; locked stays 1.
- Reset mid-frame: assert rst_n=0 during slot 2.
  - Expect all outputs 0 immediately (asynchronously).
  - After release: HUNT, no strobes until fsync.
